// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding / hazard sequencer.
// Holds the operand-mux select codes, the per-stage tracking record and the
// forwarding priority function used for both source operands.
package fwd_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 3;

  // Operand mux select codes
  localparam logic [SEL_W-1:0] FWD_RF   = 3'b000;
  localparam logic [SEL_W-1:0] FWD_EX   = 3'b001;
  localparam logic [SEL_W-1:0] FWD_MEM  = 3'b010;
  localparam logic [SEL_W-1:0] FWD_WB   = 3'b011;
  localparam logic [SEL_W-1:0] FWD_ZERO = 3'b100;

  // Link register written by JAL
  localparam logic [REG_W-1:0] REG_RA = 5'd31;

  // What each of EX/MEM/WB needs to remember about its instruction
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             wen;
    logic             is_load;
  } stage_rec_t;

  // Youngest producer wins; r0 and unused sources read constant zero
  function automatic logic [SEL_W-1:0] fwd_select(
    input logic             src_used,
    input logic [REG_W-1:0] src,
    input stage_rec_t       ex,
    input stage_rec_t       mem,
    input stage_rec_t       wb
  );
    logic [SEL_W-1:0] sel;
    sel = FWD_RF;
    if (!src_used || (src == '0)) begin
      sel = FWD_ZERO;
    end else if (ex.valid && ex.wen && (ex.dst == src)) begin
      sel = FWD_EX;
    end else if (mem.valid && mem.wen && (mem.dst == src)) begin
      sel = FWD_MEM;
    end else if (wb.valid && wb.wen && (wb.dst == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_div_busy_counter.sv
// Occupancy tracker for the multi-cycle divider.
// Ports: clk, reset (sync, active-high), load_i (divide accepted this cycle),
//        busy_o (divider occupied; high for DIV_LAT-1 cycles after load).
module div_busy_counter #(
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load on a new divide, otherwise count down to zero and rest there
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(DIV_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding and hazard sequencer beside the ID stage.
// Tracks destination registers in EX/MEM/WB, drives the rs/rt forwarding
// mux selects, and stalls ID on load-use hazards or a busy divider.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   id_*                 decoded fields of the instruction in ID
//   br_flush             EX redirect; discard the ID instruction
//   fwd_sel_rs/rt        operand mux selects (combinational)
//   stall_id             hold PC and IF/ID (combinational)
//   bubble_ex            EX receives a NOP this cycle (combinational)
//   div_busy             divider occupied
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             id_is_div,
  input  logic             id_use_hilo,
  input  logic             br_flush,
  output logic [SEL_W-1:0] fwd_sel_rs,
  output logic [SEL_W-1:0] fwd_sel_rt,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             div_busy
);

  stage_rec_t ex_q, mem_q, wb_q;
  stage_rec_t ex_d, mem_d, wb_d;

  logic rs_live, rt_live;
  logic load_use, div_hold, accept;

  // A source only creates a dependency if it is read and is not r0
  assign rs_live = id_use_rs && (id_rs != '0);
  assign rt_live = id_use_rt && (id_rt != '0);

  // Load result is not available until MEM, so a consumer right behind waits
  assign load_use = ex_q.valid && ex_q.wen && ex_q.is_load &&
                    ((rs_live && (ex_q.dst == id_rs)) ||
                     (rt_live && (ex_q.dst == id_rt)));

  assign div_hold = div_busy && (id_is_div || id_use_hilo);

  // Flush overrides every stall: the instruction is gone anyway
  assign stall_id  = id_valid && !br_flush && (load_use || div_hold);
  assign accept    = id_valid && !stall_id && !br_flush;
  assign bubble_ex = !accept;

  assign fwd_sel_rs = fwd_select(id_use_rs, id_rs, ex_q, mem_q, wb_q);
  assign fwd_sel_rt = fwd_select(id_use_rt, id_rt, ex_q, mem_q, wb_q);

  // EX/MEM/WB always advance; only entry into EX is gated
  always_comb begin
    wb_d          = mem_q;
    mem_d         = ex_q;
    ex_d          = '0;
    ex_d.valid    = accept;
    ex_d.dst      = id_dst;
    ex_d.wen      = id_wen;
    ex_d.is_load  = id_is_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  div_busy_counter #(
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_div_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept && id_is_div),
    .busy_o (div_busy)
  );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed and randomized checks of fwd_hazard_ctrl against a cycle-stamped
// reference model of the pipeline occupancy and divider reservation.
module tb_fwd_hazard_ctrl;

  localparam int unsigned DIV_LAT = 4;
  localparam int unsigned CNT_W   = 3;

  logic       clk, reset;
  logic       id_valid, id_use_rs, id_use_rt, id_wen, id_is_load, id_is_div, id_use_hilo;
  logic       br_flush;
  logic [4:0] id_rs, id_rt, id_dst;
  logic [2:0] fwd_sel_rs, fwd_sel_rt;
  logic       stall_id, bubble_ex, div_busy;

  int vectors;
  int miscompares;

  // Model: index 0 = EX, 1 = MEM, 2 = WB
  bit         m_v   [3];
  logic [4:0] m_dst [3];
  bit         m_wen [3];
  bit         m_ld  [3];
  int         m_cyc;
  int         m_div_end;
  bit         m_known;

  fwd_hazard_ctrl #(
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_dst      (id_dst),
    .id_wen      (id_wen),
    .id_is_load  (id_is_load),
    .id_is_div   (id_is_div),
    .id_use_hilo (id_use_hilo),
    .br_flush    (br_flush),
    .fwd_sel_rs  (fwd_sel_rs),
    .fwd_sel_rt  (fwd_sel_rt),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .div_busy    (div_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] exp_sel(input logic used, input logic [4:0] src);
    if (!used || src == 5'd0) return 3'd4;
    for (int s = 0; s < 3; s++) begin
      if (m_v[s] && m_wen[s] && m_dst[s] == src) return 3'(s + 1);
    end
    return 3'd0;
  endfunction

  // Divider is reserved from the cycle after acceptance until m_div_end
  function automatic bit exp_div_busy();
    return m_cyc < m_div_end;
  endfunction

  function automatic bit exp_stall();
    bit lu, dv;
    lu = m_v[0] && m_wen[0] && m_ld[0] &&
         ((id_use_rs && id_rs != 5'd0 && id_rs == m_dst[0]) ||
          (id_use_rt && id_rt != 5'd0 && id_rt == m_dst[0]));
    dv = exp_div_busy() && (id_is_div || id_use_hilo);
    return id_valid && !br_flush && (lu || dv);
  endfunction

  function automatic bit exp_accept();
    return id_valid && !br_flush && !exp_stall();
  endfunction

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic model_clock();
    bit acc;
    acc = exp_accept();
    if (reset) begin
      for (int s = 0; s < 3; s++) m_v[s] = 1'b0;
      m_div_end = 0;
      m_known   = 1'b1;
    end else begin
      if (acc && id_is_div) m_div_end = m_cyc + int'(DIV_LAT);
      for (int s = 2; s > 0; s--) begin
        m_v[s]   = m_v[s-1];
        m_dst[s] = m_dst[s-1];
        m_wen[s] = m_wen[s-1];
        m_ld[s]  = m_ld[s-1];
      end
      m_v[0]   = acc;
      m_dst[0] = id_dst;
      m_wen[0] = id_wen;
      m_ld[0]  = id_is_load;
    end
    m_cyc++;
  endtask

  // Compare all outputs against the model, then clock DUT and model together
  task automatic step();
    @(negedge clk);
    if (m_known) begin
      chk3("sel_rs", fwd_sel_rs, exp_sel(id_use_rs, id_rs));
      chk3("sel_rt", fwd_sel_rt, exp_sel(id_use_rt, id_rt));
      chk1("stall_id", stall_id, exp_stall());
      chk1("bubble_ex", bubble_ex, !exp_accept());
      chk1("div_busy", div_busy, exp_div_busy());
    end
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic wen, input logic ld, input logic dv, input logic hilo);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_dst      = dst;
    id_wen      = wen;
    id_is_load  = ld;
    id_is_div   = dv;
    id_use_hilo = hilo;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_cyc       = 0;
    m_div_end   = 0;
    m_known     = 1'b0;
    for (int s = 0; s < 3; s++) begin
      m_v[s] = 1'b0; m_dst[s] = 5'd0; m_wen[s] = 1'b0; m_ld[s] = 1'b0;
    end
    reset    = 1'b1;
    br_flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    set_id(1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk3("rst_sel_rs_r0", fwd_sel_rs, 3'd4);
    chk1("rst_div_busy", div_busy, 1'b0);
    chk1("rst_bubble", bubble_ex, 1'b0);
    step();

    // Back-to-back dependency through EX then MEM
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk3("b2b_ex", fwd_sel_rs, 3'd1);
    chk1("b2b_nostall", stall_id, 1'b0);
    step();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk3("b2b_mem", fwd_sel_rs, 3'd2);
    step();

    // Load-use: one stall, then forward from MEM
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd3, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk1("lu_stall", stall_id, 1'b1);
    chk1("lu_bubble", bubble_ex, 1'b1);
    step();
    #1;
    chk1("lu_release", stall_id, 1'b0);
    chk3("lu_fwd_mem", fwd_sel_rt, 3'd2);
    step();

    // r0 and unused sources
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd4, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk3("r0_src", fwd_sel_rs, 3'd4);
    step();
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd2, 5'd11, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk3("unused_rt", fwd_sel_rt, 3'd4);
    chk1("unused_nostall", stall_id, 1'b0);
    step();

    // Priority: three producers of r3, then with EX empty
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk3("prio_ex", fwd_sel_rs, 3'd1);
    id_valid = 1'b0;
    step();
    id_valid = 1'b1;
    #1;
    chk3("prio_mem", fwd_sel_rt, 3'd2);
    step();

    // Divider reservation followed by MFHI
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk1("div_idle", div_busy, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("mfhi_stall", stall_id, 1'b1);
      chk1("div_busy_on", div_busy, 1'b1);
      step();
    end
    #1;
    chk1("mfhi_go", stall_id, 1'b0);
    chk1("div_done", div_busy, 1'b0);
    chk1("mfhi_accept", bubble_ex, 1'b0);
    step();

    // Flush beats a load-use stall
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd2, 5'd9, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    br_flush = 1'b1;
    #1;
    chk1("flush_nostall", stall_id, 1'b0);
    chk1("flush_bubble", bubble_ex, 1'b1);
    step();
    br_flush = 1'b0;
    #1;
    chk1("flush_ex_empty", stall_id, 1'b0);
    chk3("flush_fwd_mem", fwd_sel_rt, 3'd2);
    step();

    // Reset aborts a running divide
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk1("rst_abort_div", div_busy, 1'b0);
    step();

    // Randomized traffic over a small register set to force collisions
    for (int i = 0; i < 600; i++) begin
      set_id(1'($urandom_range(3) != 0),
             5'($urandom_range(7)), 5'($urandom_range(7)),
             1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
             5'($urandom_range(7)), 1'($urandom_range(3) != 0),
             1'($urandom_range(3) == 0), 1'($urandom_range(15) == 0),
             1'($urandom_range(7) == 0));
      br_flush = 1'($urandom_range(7) == 0);
      reset    = 1'($urandom_range(63) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
